alu_shift_sequencer: RTL and testbench
======================================

Name: alu_shift_sequencer

Overview:
Multi-cycle sequencer for count-driven shift and rotate instructions (ROL, ROR, ROLC, RORC, SHL, SHR, SHRA) with a CL or immediate count. The execution unit hands it an operand, a count and the current flags. It then iterates a 1-bit step once per clock, which gives one-cycle-per-bit timing, and returns the result and the updated flags. It sits beside the combinational ALU in the execute stage. It owns the rotate-through-carry ops the ALU does not implement.

Parameters:
CNT_W, 5, count mask width; the effective count is req_count[CNT_W-1:0], range 0..31.

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request strobe
req_ready  out  1  sequencer idle, can accept a request
req_op  in  5  AluOp code, ALUOP_ROL..ALUOP_SHRA
req_size  in  1  0 = byte (bits 7:0), 1 = word
req_a  in  16  operand
req_count  in  8  raw shift count
req_flags  in  6  incoming flags, AluFlags bit order
abort  in  1  synchronous cancel of the operation in flight
busy  out  1  high in RUN and DONE
rsp_valid  out  1  one-cycle result strobe
rsp_r  out  16  result
rsp_flags  out  6  resulting flags
rsp_err  out  1  unsupported op code (valid with rsp_valid)

Behaviour:
- Single clock, clk. reset_n is asynchronous and active-low. Reset forces state IDLE, clears all registers, and drives rsp_valid=0, rsp_r=0, rsp_flags=0, rsp_err=0, busy=0. req_ready is decoded from state, so it reads 1 after reset.
- States are IDLE, RUN and DONE.
  - IDLE: req_ready=1. When req_valid is high at a clock edge, the block latches op, size, a, flags, and n = req_count[4:0].
    - If n=0, or op is not in ROL..SHRA, go to DONE.
    - Otherwise go to RUN.
  - RUN: one step per edge; n decrements each step. The edge that performs the last step moves the state to DONE.
  - DONE: rsp_valid=1 for exactly one cycle, then return to IDLE. There is no response backpressure.
- Latency: rsp_valid is high in the cycle that begins n edges after the accept edge. For n=0 this is the cycle immediately after accept.
- req_ready=0 in RUN and DONE. req_valid is ignored outside IDLE.
- Width rules (msb is 7 or 15):
  - Byte ops modify bits 7:0 only.
  - Bits 15:8 pass through unchanged.
- Step rules (w is the working register, CY the carry):
  - ROL: CY = w[msb]; rotate left.
  - ROR: CY = w[0]; rotate right.
  - ROLC: new lsb = CY; CY = old w[msb].
  - RORC: new msb = CY; CY = old w[0].
  - SHL: CY = w[msb]; shift in 0.
  - SHR: CY = w[0]; 0 into msb.
  - SHRA: CY = w[0]; msb is kept.
- Flags for n≥1. Bit indices: AC=0, CY=1, V=2, P=3, S=4, Z=5.
  - CY: from the last step.
  - V:
    - ROL, ROLC, SHL: r[msb]^CY.
    - ROR, RORC: r[msb]^r[msb-1].
    - SHR: operand msb before the last step.
    - SHRA: 0.
  - Z, S, P: updated for SHL, SHR and SHRA only. P = 1 when r[7:0] has even parity.
  - Rotates leave Z, S and P unchanged. AC is always unchanged.
- When n=0 or the op is unsupported: rsp_r = req_a and rsp_flags = req_flags. rsp_err=1 for an unsupported op only.
- Counts above the rotate width iterate naturally. Example: a byte RORC with count 9 returns the original operand and carry.
- abort:
  - In RUN or DONE, the next state is IDLE and rsp_valid is not asserted (if abort coincides with DONE, the strobe is suppressed).
  - In IDLE, abort has no effect and wins over req_valid.
- When reset_n is asserted mid-operation, the state goes to IDLE immediately and no response is issued.

Decomposition:
- Shared package alu_pkg holds:
  - the AluOp and AluFlags enums, moved out of the ALU source;
  - the MSB-select helper;
  - the byte parity function.
- Sub-module shift_step: combinational single-bit step. Inputs are op, size, w and CY; outputs are w_next, CY_next and v_next.
- The sequencer holds the FSM, the count register and flag assembly.

Test Plan:
1. ROL, byte, a=0x0081, n=1, flags=0 -> rsp_r=0x0003, CY=1, V=1; rsp_valid 1 edge after accept; Z/S/P unchanged.
2. RORC, word, a=0x0001, CY=0, n=17 -> rsp_r=0x0001, CY=0; rsp_valid 17 edges after accept; req_ready low throughout.
3. SHL, byte, a=0x12F0, n=4 -> rsp_r=0x1200, CY=1, Z=1, S=0, P=1.
4. SHR, word, a=0xBEEF, req_count=0x20 (masked to 0), flags=0x2A -> rsp_r=0xBEEF, rsp_flags=0x2A; rsp_valid in the cycle right after accept.
5. SHRA, word, a=0x8000, n=3 -> rsp_r=0xF000, CY=0, S=1, Z=0, V=0. Second case: abort after 2 steps of an n=10 op -> no rsp_valid, req_ready=1 next cycle.
6. reset_n low mid-RUN -> busy=0 immediately, no rsp_valid; the next request completes correctly. Op=ALUOP_ADD -> rsp_err=1 with passthrough result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types and helpers: op codes, flag bit positions, msb select, parity.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    // ALU op codes; the rotate/shift group ROL..SHRA must stay contiguous.
    typedef enum logic [4:0] {
        ALUOP_ADD  = 5'd0,
        ALUOP_ADC  = 5'd1,
        ALUOP_SUB  = 5'd2,
        ALUOP_SBB  = 5'd3,
        ALUOP_AND  = 5'd4,
        ALUOP_OR   = 5'd5,
        ALUOP_XOR  = 5'd6,
        ALUOP_NOT  = 5'd7,
        ALUOP_NEG  = 5'd8,
        ALUOP_INC  = 5'd9,
        ALUOP_DEC  = 5'd10,
        ALUOP_ROL  = 5'd11,
        ALUOP_ROR  = 5'd12,
        ALUOP_ROLC = 5'd13,
        ALUOP_RORC = 5'd14,
        ALUOP_SHL  = 5'd15,
        ALUOP_SHR  = 5'd16,
        ALUOP_SHRA = 5'd17,
        ALUOP_CMP  = 5'd18,
        ALUOP_TEST = 5'd19,
        ALUOP_PASS = 5'd20
    } alu_op_e;

    // Bit positions inside the 6-bit flags word.
    typedef enum logic [2:0] {
        FLAG_AC = 3'd0,
        FLAG_CY = 3'd1,
        FLAG_V  = 3'd2,
        FLAG_P  = 3'd3,
        FLAG_S  = 3'd4,
        FLAG_Z  = 3'd5
    } alu_flag_e;

    // Same layout as alu_flag_e, msb first.
    typedef struct packed {
        logic z;
        logic s;
        logic p;
        logic v;
        logic cy;
        logic ac;
    } alu_flags_t;

    // Index of the operand msb: 7 for byte, 15 for word.
    function automatic logic [3:0] msb_of(input logic size);
        return size ? 4'd15 : 4'd7;
    endfunction

    // 1 when the byte holds an even number of ones.
    function automatic logic parity8(input logic [7:0] b);
        return ~^b;
    endfunction

    // Ops this sequencer iterates; everything else is passed through with an error.
    function automatic logic is_seq_op(input logic [4:0] op);
        return (op >= ALUOP_ROL) && (op <= ALUOP_SHRA);
    endfunction

    // Shifts (not rotates) refresh Z, S and P.
    function automatic logic is_shift_op(input alu_op_e op);
        return (op == ALUOP_SHL) || (op == ALUOP_SHR) || (op == ALUOP_SHRA);
    endfunction

endpackage

// File: rtl/alu_shift_sequencer_if.sv
// Request/response bundle between the execute stage and the shift sequencer.
// Latency: n/a (wires only).
// Backpressure: request side uses req_valid/req_ready; response is a bare strobe.
interface alu_shift_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic        req_size;
    logic [15:0] req_a;
    logic [7:0]  req_count;
    logic [5:0]  req_flags;
    logic        abort;
    logic        busy;
    logic        rsp_valid;
    logic [15:0] rsp_r;
    logic [5:0]  rsp_flags;
    logic        rsp_err;

    // Execute-stage side.
    modport master (
        output req_valid, req_op, req_size, req_a, req_count, req_flags, abort,
        input  req_ready, busy, rsp_valid, rsp_r, rsp_flags, rsp_err
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_size, req_a, req_count, req_flags, abort,
        output req_ready, busy, rsp_valid, rsp_r, rsp_flags, rsp_err
    );
endinterface

// File: rtl/shift_step.sv
// One-bit rotate/shift step on a byte or word working register, with carry and overflow.
// Latency: combinational.
// Backpressure: none.
module shift_step
    import alu_pkg::*;
(
    input  alu_op_e     op,
    input  logic        size,
    input  logic [15:0] w,
    input  logic        cy,
    output logic [15:0] w_next,
    output logic        cy_next,
    output logic        v_next
);

    logic [3:0] m;
    assign m = msb_of(size);

    // Move one bit left or right; byte ops leave bits 15:8 untouched.
    always_comb begin
        logic lsb_in;
        logic msb_in;
        logic [15:0] left;
        w_next  = w;
        cy_next = cy;
        v_next  = 1'b0;
        lsb_in  = 1'b0;
        msb_in  = 1'b0;
        left    = '0;
        unique case (op)
            ALUOP_ROL, ALUOP_ROLC, ALUOP_SHL: begin
                lsb_in  = (op == ALUOP_ROL)  ? w[m] :
                          (op == ALUOP_ROLC) ? cy   : 1'b0;
                left    = {w[14:0], lsb_in};
                w_next  = size ? left : {w[15:8], left[7:0]};
                cy_next = w[m];
                v_next  = w_next[m] ^ cy_next;
            end
            ALUOP_ROR, ALUOP_RORC, ALUOP_SHR, ALUOP_SHRA: begin
                msb_in  = (op == ALUOP_ROR)  ? w[0] :
                          (op == ALUOP_RORC) ? cy   :
                          (op == ALUOP_SHRA) ? w[m] : 1'b0;
                w_next  = size ? {msb_in, w[15:1]} : {w[15:8], msb_in, w[7:1]};
                cy_next = w[0];
                if (op == ALUOP_SHR)
                    v_next = w[m];
                else if (op == ALUOP_SHRA)
                    v_next = 1'b0;
                else
                    v_next = w_next[m] ^ w_next[m - 4'd1];
            end
            default: begin
                w_next  = w;
                cy_next = cy;
                v_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle rotate/shift sequencer: one bit per clock, result and flags on a one-cycle strobe.
// Latency: rsp_valid n cycles after accept (next cycle when n=0 or op unsupported).
// Backpressure: req_ready only in IDLE; no response backpressure, abort drops the operation.
module alu_shift_sequencer
    import alu_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_shift_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    alu_op_e     op_q;
    logic        size_q;
    logic [15:0] w_q;
    logic        cy_q;
    logic        v_q;
    logic [CNT_W-1:0] n_q;
    alu_flags_t  flags_q;
    logic        err_q;
    logic        stepped_q;

    logic        accept;
    logic        step;
    logic [CNT_W-1:0] req_n;
    logic [15:0] w_next;
    logic        cy_next;
    logic        v_next;
    logic        unused_cnt_hi;

    assign req_n         = bus.req_count[CNT_W-1:0];
    assign unused_cnt_hi = ^bus.req_count[7:CNT_W];

    shift_step u_step (
        .op      (op_q),
        .size    (size_q),
        .w       (w_q),
        .cy      (cy_q),
        .w_next  (w_next),
        .cy_next (cy_next),
        .v_next  (v_next)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state; abort beats a new request in IDLE and kills RUN/DONE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && !bus.abort) begin
                    accept  = 1'b1;
                    state_d = (req_n == '0 || !is_seq_op(bus.req_op)) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (n_q == CNT_W'(1))
                        state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture on accept, then one working-register update per RUN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= ALUOP_ADD;
            size_q    <= 1'b0;
            w_q       <= '0;
            cy_q      <= 1'b0;
            v_q       <= 1'b0;
            n_q       <= '0;
            flags_q   <= '0;
            err_q     <= 1'b0;
            stepped_q <= 1'b0;
        end else if (accept) begin
            op_q      <= alu_op_e'(bus.req_op);
            size_q    <= bus.req_size;
            w_q       <= bus.req_a;
            cy_q      <= bus.req_flags[FLAG_CY];
            v_q       <= bus.req_flags[FLAG_V];
            n_q       <= req_n;
            flags_q   <= alu_flags_t'(bus.req_flags);
            err_q     <= !is_seq_op(bus.req_op);
            stepped_q <= 1'b0;
        end else if (step) begin
            w_q       <= w_next;
            cy_q      <= cy_next;
            v_q       <= v_next;
            n_q       <= n_q - CNT_W'(1);
            stepped_q <= 1'b1;
        end
    end

    // Flag assembly: untouched on passthrough, CY/V after any step, Z/S/P only for shifts.
    always_comb begin
        alu_flags_t f;
        logic [3:0] m;
        f = flags_q;
        m = msb_of(size_q);
        if (stepped_q) begin
            f.cy = cy_q;
            f.v  = v_q;
            if (is_shift_op(op_q)) begin
                f.z = size_q ? (w_q == 16'h0000) : (w_q[7:0] == 8'h00);
                f.s = w_q[m];
                f.p = parity8(w_q[7:0]);
            end
        end
        bus.rsp_flags = f;
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_DONE) && !bus.abort;
    assign bus.rsp_r     = w_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Randomized and directed bench for the shift sequencer against an arithmetic reference model.
// Latency: checks the exact response cycle of every request.
// Backpressure: checks req_ready/busy while the sequencer is occupied and abort behaviour.
module tb_alu_shift_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_shift_sequencer_if sif ();

    alu_shift_sequencer #(.CNT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-count rotations/shifts with plain integer arithmetic.
    function automatic void model(input logic [4:0] op, input logic size, input logic [15:0] a,
                                  input logic [7:0] cnt, input logic [5:0] fin,
                                  output logic [15:0] r, output logic [5:0] fo, output logic err);
        int n, w, k;
        longint x, mask, res, y, m1, sx, tmp;
        logic cy, v;
        n    = int'(cnt[4:0]);
        w    = size ? 16 : 8;
        mask = (64'sd1 <<< w) - 1;
        x    = size ? longint'(a) : longint'(a[7:0]);
        r    = a;
        fo   = fin;
        err  = !(op >= ALUOP_ROL && op <= ALUOP_SHRA);
        if (err || n == 0) return;
        res = 0; cy = 1'b0; v = 1'b0; tmp = 0;
        m1  = (64'sd1 <<< (w + 1)) - 1;
        y   = x | (longint'(fin[1]) <<< w);
        case (op)
            ALUOP_ROL: begin
                k = n % w;
                res = ((x <<< k) | (x >>> (w - k))) & mask;
                cy = res[0];
            end
            ALUOP_ROR: begin
                k = n % w;
                res = ((x >>> k) | (x <<< (w - k))) & mask;
                cy = res[w-1];
            end
            ALUOP_ROLC: begin
                k = n % (w + 1);
                y = ((y <<< k) | (y >>> (w + 1 - k))) & m1;
                res = y & mask;
                cy = y[w];
            end
            ALUOP_RORC: begin
                k = n % (w + 1);
                y = ((y >>> k) | (y <<< (w + 1 - k))) & m1;
                res = y & mask;
                cy = y[w];
            end
            ALUOP_SHL: begin
                tmp = x <<< n;
                res = tmp & mask;
                cy = tmp[w];
            end
            ALUOP_SHR: begin
                res = x >>> n;
                tmp = x >>> (n - 1);
                cy = tmp[0];
                v = tmp[w-1];
            end
            default: begin
                sx = x;
                if (x[w-1]) sx = x - (64'sd1 <<< w);
                res = (sx >>> n) & mask;
                tmp = sx >>> (n - 1);
                cy = tmp[0];
            end
        endcase
        if (op == ALUOP_ROL || op == ALUOP_ROLC || op == ALUOP_SHL) v = res[w-1] ^ cy;
        if (op == ALUOP_ROR || op == ALUOP_RORC) v = res[w-1] ^ res[w-2];
        fo[1] = cy;
        fo[2] = v;
        if (op == ALUOP_SHL || op == ALUOP_SHR || op == ALUOP_SHRA) begin
            fo[5] = (res == 0);
            fo[4] = res[w-1];
            fo[3] = ($countones(res[7:0]) % 2) == 0;
        end
        r = size ? res[15:0] : {a[15:8], res[7:0]};
    endfunction

    // Issue one request, follow it to its response and compare against the model.
    task automatic run_req(input string tag, input logic [4:0] op, input logic size,
                           input logic [15:0] a, input logic [7:0] cnt, input logic [5:0] fl,
                           input bit hold, output logic [15:0] got_r, output logic [5:0] got_f,
                           output logic got_e);
        logic [15:0] er;
        logic [5:0]  ef;
        logic        ee;
        int          exp_lat, lat;
        bit          seen, occ_ok;
        model(op, size, a, cnt, fl, er, ef, ee);
        exp_lat = ee ? 0 : int'(cnt[4:0]);
        @(negedge clk);
        sif.req_op = op; sif.req_size = size; sif.req_a = a;
        sif.req_count = cnt; sif.req_flags = fl; sif.req_valid = 1'b1;
        @(negedge clk);
        if (hold) begin
            sif.req_a = 16'($urandom); sif.req_count = 8'd1;
        end else begin
            sif.req_valid = 1'b0;
        end
        lat = 0; seen = 0; occ_ok = 1;
        got_r = '0; got_f = '0; got_e = 1'b0;
        while (!seen && lat <= 40) begin
            if (sif.rsp_valid) begin
                seen = 1;
                got_r = sif.rsp_r; got_f = sif.rsp_flags; got_e = sif.rsp_err;
                sif.req_valid = 1'b0;
                if (sif.req_ready || !sif.busy) occ_ok = 0;
            end else begin
                if (sif.req_ready || !sif.busy) occ_ok = 0;
                @(negedge clk);
                lat++;
            end
        end
        sif.req_valid = 1'b0;
        check({tag, " rsp_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " latency"}, lat, exp_lat);
            check({tag, " rsp_r"}, 32'(got_r), 32'(er));
            check({tag, " rsp_flags"}, 32'(got_f), 32'(ef));
            check({tag, " rsp_err"}, 32'(got_e), 32'(ee));
        end
        check({tag, " occupied"}, 32'(occ_ok), 32'd1);
        @(negedge clk);
        check({tag, " strobe_1cyc"}, {sif.rsp_valid, sif.req_ready}, 32'b01);
    endtask

    // Count response strobes over a window; used after abort/reset.
    task automatic count_strobes(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            if (sif.rsp_valid) hits++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] r;
        logic [5:0]  f;
        logic        e;
        int          hits;
        logic [4:0]  op;
        sif.req_valid = 1'b0; sif.req_op = '0; sif.req_size = 1'b0; sif.req_a = '0;
        sif.req_count = '0; sif.req_flags = '0; sif.abort = 1'b0;

        repeat (3) @(negedge clk);
        check("reset ready/busy/valid", {sif.req_ready, sif.busy, sif.rsp_valid}, 32'b100);
        check("reset rsp_r", 32'(sif.rsp_r), 32'h0);
        check("reset rsp_flags/err", {sif.rsp_flags, sif.rsp_err}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        run_req("t1 rol", ALUOP_ROL, 1'b0, 16'h0081, 8'd1, 6'h00, 0, r, f, e);
        check("t1 r", 32'(r), 32'h0003);
        check("t1 flags", 32'(f), 32'h06);

        run_req("t2 rorc", ALUOP_RORC, 1'b1, 16'h0001, 8'd17, 6'h00, 0, r, f, e);
        check("t2 r", 32'(r), 32'h0001);
        check("t2 flags", 32'(f), 32'h00);

        run_req("t3 shl", ALUOP_SHL, 1'b0, 16'h12F0, 8'd4, 6'h00, 0, r, f, e);
        check("t3 r", 32'(r), 32'h1200);
        check("t3 flags", 32'(f), 32'h2E);

        run_req("t4 shr0", ALUOP_SHR, 1'b1, 16'hBEEF, 8'h20, 6'h2A, 0, r, f, e);
        check("t4 r", 32'(r), 32'hBEEF);
        check("t4 flags", 32'(f), 32'h2A);

        run_req("t5 shra", ALUOP_SHRA, 1'b1, 16'h8000, 8'd3, 6'h00, 0, r, f, e);
        check("t5 r", 32'(r), 32'hF000);
        check("t5 flags", 32'(f), 32'h18);

        run_req("rorc9", ALUOP_RORC, 1'b0, 16'h5A3C, 8'd9, 6'h03, 0, r, f, e);
        check("rorc9 r", 32'(r), 32'h5A3C);
        check("rorc9 flags", 32'(f), 32'h03);

        run_req("add err", ALUOP_ADD, 1'b1, 16'h1234, 8'd5, 6'h15, 0, r, f, e);
        check("add err bit", 32'(e), 32'd1);
        check("add passthru", {r, 2'b00, f}, {16'h1234, 2'b00, 6'h15});

        // Abort two steps into a 10-step op.
        @(negedge clk);
        sif.req_op = ALUOP_SHRA; sif.req_size = 1'b1; sif.req_a = 16'h8000;
        sif.req_count = 8'd10; sif.req_flags = 6'h00; sif.req_valid = 1'b1;
        @(negedge clk);
        sif.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        check("abort run ready/busy", {sif.req_ready, sif.busy}, 32'b10);
        count_strobes(15, hits);
        check("abort run no strobe", hits, 0);

        // Abort landing on the DONE cycle suppresses the strobe.
        sif.req_op = ALUOP_SHL; sif.req_size = 1'b0; sif.req_a = 16'h0011;
        sif.req_count = 8'd2; sif.req_valid = 1'b1;
        @(negedge clk);
        sif.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        sif.abort = 1'b1;
        #1;
        check("abort done busy", 32'(sif.busy), 32'd1);
        check("abort done strobe", 32'(sif.rsp_valid), 32'd0);
        @(negedge clk);
        sif.abort = 1'b0;
        check("abort done ready", 32'(sif.req_ready), 32'd1);
        count_strobes(5, hits);
        check("abort done no strobe", hits, 0);

        // Abort in IDLE beats a simultaneous request.
        sif.req_valid = 1'b1; sif.abort = 1'b1; sif.req_count = 8'd3;
        @(negedge clk);
        check("idle abort not accepted", {sif.req_ready, sif.busy}, 32'b10);
        sif.req_valid = 1'b0; sif.abort = 1'b0;

        // Reset asserted mid-RUN.
        sif.req_op = ALUOP_ROL; sif.req_size = 1'b1; sif.req_a = 16'hA5A5;
        sif.req_count = 8'd20; sif.req_valid = 1'b1;
        @(negedge clk);
        sif.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid reset busy/valid/ready", {sif.busy, sif.rsp_valid, sif.req_ready}, 32'b001);
        check("mid reset rsp_r", 32'(sif.rsp_r), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        count_strobes(25, hits);
        check("mid reset no strobe", hits, 0);
        run_req("post reset", ALUOP_ROLC, 1'b1, 16'h8001, 8'd3, 6'h02, 0, r, f, e);

        // Randomized requests, some holding req_valid high while busy.
        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(ALUOP_ROL + $urandom_range(0, 6));
            run_req($sformatf("rnd%0d", i), op, 1'($urandom), 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 18)),
                    6'($urandom), bit'($urandom_range(0, 3) == 0), r, f, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
